coil_gpio_pio_v2: RTL and testbench
===================================

# coil_gpio_pio_v2

Parametrised successor to the CurrCTRL GPIO peripheral in the coil-driver CPU subsystem. Memory-mapped register slave with a WIDTH-bit output port and a WIDTH-bit input port. Adds per-bit input debounce, per-bit rising/falling edge selection, write-1-to-clear edge capture, an interrupt mask and a level IRQ output. Sits on the CPU data bus and drives or senses coil-driver control and status lines.

## Interface
- WIDTH, 32: port and register width, 1..32.
- DEBOUNCE_CYCLES, 0: input stability window in clk cycles; 0 bypasses the filter.
- DEBOUNCE_W, 8: debounce counter width; must satisfy 2^DEBOUNCE_W > DEBOUNCE_CYCLES.
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word register index.
- chipselect  in  1  qualifies reads and writes.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data; bits at or above WIDTH are ignored.
- readdata  out  32  registered read data, zero-extended above WIDTH.
- in_port  in  WIDTH  asynchronous input pins.
- out_port  out  WIDTH  output data register.
- irq  out  1  level interrupt request.

## Operation
- Register map:
  - 0 DATA: read returns the filtered input; write loads out_port.
  - 1 (reserved): reads 0; writes ignored.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAP: read returns captured edges; write clears each bit where writedata=1 (W1C).
  - 4 OUTSET: write sets out_port bits where writedata=1; reads 0.
  - 5 OUTCLR: write clears out_port bits where writedata=1; reads 0.
  - 6 RISE_EN: read/write.
  - 7 FALL_EN: read/write.
- Reset values: out_port=0, IRQ_MASK=0, EDGE_CAP=0, RISE_EN=0, FALL_EN=all ones, readdata=0, irq=0. The FALL_EN reset value keeps legacy falling-edge behaviour.
- Reset also clears the synchroniser flops, the filtered value, the previous filtered value and all debounce counters to 0.
- Input path, per bit:
  - in_port passes through a 2-flop synchroniser (sync1, sync2).
  - With DEBOUNCE_CYCLES=0: filt = sync2, combinationally.
  - Otherwise each bit has its own counter cnt:
    - If sync2==filt: cnt <= 0.
    - Else if cnt==DEBOUNCE_CYCLES-1: filt <= sync2 and cnt <= 0.
    - Else: cnt <= cnt+1.
  - prev <= filt every cycle.
- Edge detection and capture:
  - rise = filt & ~prev & RISE_EN; fall = ~filt & prev & FALL_EN.
  - EDGE_CAP[i] <= 1 on (rise|fall)[i]; otherwise it clears on a W1C write of bit i.
  - If an edge and a W1C clear hit the same bit in the same cycle, set wins.
- irq = |(EDGE_CAP & IRQ_MASK). It is derived combinationally from registers and is glitch-free.
- When OUTSET or OUTCLR is written, the register is read-modify-written in one cycle; there are no other simultaneous sources.
- Accesses with chipselect=0 are ignored. readdata still updates every cycle from address: reads have no side effects, so reads need no chipselect qualification.

## Timing
- Read latency: readdata is registered and reflects the state at the clk edge where the address was presented. Data is valid the following cycle.
- Writes take effect at the clk edge where the write is presented. out_port and the affected registers change on that edge.
- Input latency: take an in_port change that is stable before edge k.
  - sync2 updates at edge k+1.
  - filt updates at edge k+1+DEBOUNCE_CYCLES.
  - EDGE_CAP bit and irq update at edge k+2+DEBOUNCE_CYCLES.
- Glitch rejection: a change in sync2 lasting fewer than DEBOUNCE_CYCLES cycles never reaches filt, and the counter restarts from 0.
- Reset asserted mid-debounce or with a pending capture: at the next clk edge every state element is at its reset value and irq=0 immediately.
- Changing RISE_EN or FALL_EN affects only edges detected from the following cycle. It never alters bits already in EDGE_CAP.

## Test plan
- Reset: hold reset 2 cycles -> out_port=0, irq=0; read FALL_EN=0xFFFFFFFF and RISE_EN=0 (WIDTH=32).
- Out registers: write DATA=0x00F0, OUTSET=0x000F, OUTCLR=0x0030 -> out_port=0x00CF; reading OUTSET returns 0.
- Default edge: DEBOUNCE_CYCLES=0, IRQ_MASK=0x1, in_port[0] 1->0 at edge k -> EDGE_CAP=0x1 and irq=1 at edge k+2. A 0->1 transition captures nothing.
- Edge selection and W1C: RISE_EN=0x3, FALL_EN=0; pulse bits 0 and 1 high -> EDGE_CAP=0x3. Write EDGE_CAP=0x1 -> EDGE_CAP=0x2. A W1C on bit 1 in the same cycle as a new bit-1 edge leaves bit 1 set.
- Debounce: DEBOUNCE_CYCLES=4; a 3-cycle high glitch -> filt stays 0 and no capture. A 5-cycle high pulse -> filt=1 at edge k+5 and capture at edge k+6.
- Reset mid-operation: assert reset with cnt=2 and EDGE_CAP=0x5 -> the next edge shows EDGE_CAP=0 and irq=0. After release, a stable input change requires the full DEBOUNCE_CYCLES again.

Source files
------------

// File: rtl/coil_gpio_pio_v2.sv
// coil_gpio_pio_v2: memory-mapped GPIO with a synchronised and debounced input path,
// per-bit rise/fall edge capture (W1C), interrupt mask and a level IRQ.
module coil_gpio_pio_v2 #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned DEBOUNCE_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd6;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd7;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [31:0]      r_readdata;

  logic [WIDTH-1:0] w_filt;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_cap_clr;
  logic [WIDTH-1:0] w_rdata;
  logic             w_wr;
  logic             w_unused_wdata;

  assign w_wr           = chipselect & ~write_n;
  assign w_wdata        = writedata[WIDTH-1:0];
  assign w_unused_wdata = ^writedata;

  // Input filter: straight through when the window is zero, else a per-bit stability counter
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign w_filt = r_sync2;
    end else begin : g_debounce
      localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [DEBOUNCE_W-1:0] r_cnt;
        logic                  r_filt;

        always_ff @(posedge clk) begin
          if (reset) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
          end else if (r_sync2[gi] == r_filt) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_filt <= r_sync2[gi];
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + DEBOUNCE_W'(1);
          end
        end

        assign w_filt[gi] = r_filt;
      end
    end
  endgenerate

  assign w_edge    = (w_filt & ~r_prev & r_rise_en) | (~w_filt & r_prev & r_fall_en);
  assign w_cap_clr = (w_wr && (address == ADDR_EDGE_CAP)) ? w_wdata : '0;

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA:     w_rdata = w_filt;
      ADDR_IRQ_MASK: w_rdata = r_mask;
      ADDR_EDGE_CAP: w_rdata = r_edge_cap;
      ADDR_RISE_EN:  w_rdata = r_rise_en;
      ADDR_FALL_EN:  w_rdata = r_fall_en;
      default:       w_rdata = '0;
    endcase
  end

  // Register file, synchroniser and edge capture; a new edge beats a same-cycle W1C
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= '0;
      r_out      <= '0;
      r_mask     <= '0;
      r_edge_cap <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '1;
      r_readdata <= '0;
    end else begin
      r_sync1    <= in_port;
      r_sync2    <= r_sync1;
      r_prev     <= w_filt;
      r_edge_cap <= (r_edge_cap & ~w_cap_clr) | w_edge;
      r_readdata <= 32'(w_rdata);
      if (w_wr) begin
        case (address)
          ADDR_DATA:     r_out     <= w_wdata;
          ADDR_IRQ_MASK: r_mask    <= w_wdata;
          ADDR_OUTSET:   r_out     <= r_out | w_wdata;
          ADDR_OUTCLR:   r_out     <= r_out & ~w_wdata;
          ADDR_RISE_EN:  r_rise_en <= w_wdata;
          ADDR_FALL_EN:  r_fall_en <= w_wdata;
          default:       ;
        endcase
      end
    end
  end

  assign readdata = r_readdata;
  assign out_port = r_out;
  assign irq      = |(r_edge_cap & r_mask);

endmodule

// File: tb/tb_coil_gpio_pio_v2.sv
// Directed bench for coil_gpio_pio_v2: one instance without debounce, one with a 4-cycle window.
module tb_coil_gpio_pio_v2;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in0, in4;
  logic [31:0] rd0, rd4;
  logic [31:0] out0, out4;
  logic        irq0, irq4;

  typedef struct {
    string       tag;
    logic [31:0] e0;
    logic [31:0] e4;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  coil_gpio_pio_v2 #(.WIDTH(32), .DEBOUNCE_CYCLES(0), .DEBOUNCE_W(8)) u_dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0),
    .in_port(in0), .out_port(out0), .irq(irq0)
  );

  coil_gpio_pio_v2 #(.WIDTH(32), .DEBOUNCE_CYCLES(4), .DEBOUNCE_W(8)) u_dut4 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd4),
    .in_port(in4), .out_port(out4), .irq(irq4)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a read for one edge; expected values queue up and are checked when readdata lands
  task automatic rd(input logic [2:0] a, input logic [31:0] e0, input logic [31:0] e4,
                    input string tag);
    exp_t e;
    address    = a;
    chipselect = 1'b0;
    write_n    = 1'b1;
    e.tag = tag;
    e.e0  = e0;
    e.e4  = e4;
    sb.push_back(e);
    tick(1);
    e = sb.pop_front();
    chk({e.tag, "_d0"}, rd0, e.e0);
    chk({e.tag, "_d4"}, rd4, e.e4);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in0        = 32'h0;
    in4        = 32'h0;

    // Reset state
    tick(2);
    reset = 1'b0;
    chk("rst_out0", out0, 32'h0);
    chk("rst_out4", out4, 32'h0);
    chk("rst_irq0", {31'h0, irq0}, 32'h0);
    chk("rst_irq4", {31'h0, irq4}, 32'h0);
    rd(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "rst_fall_en");
    rd(3'd6, 32'h0, 32'h0, "rst_rise_en");

    // Output register writes
    wr(3'd0, 32'h0000_00F0);
    wr(3'd4, 32'h0000_000F);
    wr(3'd5, 32'h0000_0030);
    chk("out_rmw0", out0, 32'h0000_00CF);
    chk("out_rmw4", out4, 32'h0000_00CF);
    rd(3'd4, 32'h0, 32'h0, "outset_rd");
    rd(3'd1, 32'h0, 32'h0, "resv_rd");
    address    = 3'd0;
    writedata  = 32'h1234_5678;
    chipselect = 1'b0;
    write_n    = 1'b0;
    tick(1);
    write_n = 1'b1;
    chk("cs0_ignored", out0, 32'h0000_00CF);

    // Default falling-edge capture, no debounce
    wr(3'd2, 32'h1);
    in0 = 32'h1;
    tick(3);
    rd(3'd3, 32'h0, 32'h0, "rise_ignored");
    chk("rise_noirq", {31'h0, irq0}, 32'h0);
    in0 = 32'h0;
    tick(2);
    chk("fall_k1_irq", {31'h0, irq0}, 32'h0);
    tick(1);
    chk("fall_k2_irq", {31'h0, irq0}, 32'h1);
    rd(3'd3, 32'h1, 32'h0, "fall_cap");
    wr(3'd3, 32'h1);
    chk("w1c_irq", {31'h0, irq0}, 32'h0);

    // Edge selection and W1C
    wr(3'd6, 32'h3);
    wr(3'd7, 32'h0);
    in0 = 32'h3;
    tick(1);
    in0 = 32'h0;
    tick(4);
    rd(3'd3, 32'h3, 32'h0, "rise_cap");
    wr(3'd3, 32'h1);
    rd(3'd3, 32'h2, 32'h0, "w1c_bit0");
    wr(3'd3, 32'h2);
    rd(3'd3, 32'h0, 32'h0, "w1c_bit1");
    in0 = 32'h2;
    tick(2);
    wr(3'd3, 32'h2);
    rd(3'd3, 32'h2, 32'h0, "set_wins");
    in0 = 32'h0;
    tick(3);
    wr(3'd3, 32'hFFFF_FFFF);
    rd(3'd3, 32'h0, 32'h0, "cap_cleared");

    // Debounce: 3-cycle glitch rejected
    in4 = 32'h1;
    tick(3);
    in4 = 32'h0;
    tick(6);
    rd(3'd0, 32'h0, 32'h0, "glitch_filt");
    rd(3'd3, 32'h0, 32'h0, "glitch_cap");
    chk("glitch_irq", {31'h0, irq4}, 32'h0);

    // Debounce: 5-cycle pulse passes, filt at k+5, capture at k+6
    in4 = 32'h1;
    tick(4);
    rd(3'd0, 32'h0, 32'h0, "pulse_filt_k3");
    in4 = 32'h0;
    rd(3'd0, 32'h0, 32'h0, "pulse_filt_k4");
    chk("pulse_irq_k5", {31'h0, irq4}, 32'h0);
    rd(3'd0, 32'h0, 32'h1, "pulse_filt_k5");
    chk("pulse_irq_k6", {31'h0, irq4}, 32'h1);

    // Build EDGE_CAP=0x5 and a mid-window counter, then reset
    tick(8);
    wr(3'd6, 32'h7);
    in4 = 32'h4;
    tick(10);
    rd(3'd3, 32'h0, 32'h5, "cap5");
    chk("cap5_irq", {31'h0, irq4}, 32'h1);
    in4 = 32'h0;
    tick(4);
    reset = 1'b1;
    tick(1);
    chk("midrst_irq4", {31'h0, irq4}, 32'h0);
    chk("midrst_irq0", {31'h0, irq0}, 32'h0);
    chk("midrst_out4", out4, 32'h0);
    reset = 1'b0;
    rd(3'd3, 32'h0, 32'h0, "midrst_cap");
    rd(3'd0, 32'h0, 32'h0, "midrst_filt");

    // Full debounce window required again after reset
    in4 = 32'h1;
    tick(4);
    rd(3'd0, 32'h0, 32'h0, "post_k3");
    rd(3'd0, 32'h0, 32'h0, "post_k4");
    rd(3'd0, 32'h0, 32'h1, "post_k5");
    rd(3'd3, 32'h0, 32'h0, "post_nocap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
